booth_seq_multiplier: RTL
=========================

// Module: booth_seq_multiplier
// PURPOSE
//  Multi-cycle signed 32x32 multiplier, radix-2 Booth, one add/sub step per clock.
//  Sits beside the ALU in the execute stage and drives the carry-select adder datapath.
//  The ALU result mux consumes product/overflow on result_valid.
//  Replaces a combinational array multiplier to save area; one operation in flight.
// PARAMETERS
//  WIDTH   32  operand/product-low width; adder datapath is WIDTH+1 bits
//  CNT_W   6   iteration counter width; must hold WIDTH
// PORTS
//  clock          in   1      single clock, all state on rising edge
//  reset          in   1      synchronous, active-high
//  start          in   1      request; sampled only when busy==0
//  multiplicand   in   WIDTH  signed operand M, sampled with accepted start
//  multiplier     in   WIDTH  signed operand Q, sampled with accepted start
//  busy           out  1      high while an operation is in progress
//  result_valid   out  1      one-cycle pulse, product/overflow valid
//  product        out  WIDTH  low word of signed product, held until next accept
//  overflow       out  1      signed product does not fit in WIDTH bits
//  product_hi     out  WIDTH  high word; present only with MULT_PRODUCT_HI_EN
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Reset (any state, incl. mid-run):
//    state=IDLE, busy=0, result_valid=0, product=0, overflow=0, product_hi=0, counter=0.
//  - FSM: IDLE -(start)-> RUN -(counter==WIDTH-1 step done)-> DONE -> IDLE,
//    or DONE -(start)-> RUN.
//  - Accept: start=1 and busy=0 (IDLE or DONE) at edge E0. Latch M, A=0 (WIDTH+1 b),
//    Q=multiplier, q_m1=0, counter=0, busy=1 from E0.
//  - RUN: each edge does one Booth step on {Q[0],q_m1}: 01 -> A+=M, 10 -> A-=M,
//    00/11 -> no add. M is sign-extended to WIDTH+1. Then arith-shift {A,Q,q_m1} right 1.
//  - Subtract uses ~M with carry_in=1 (same adder, no separate subtractor).
//  - After 32 steps (edges E1..E32), state=DONE at E32: product=Q (low word),
//    product_hi=A[WIDTH-1:0], result_valid=1, busy=0 for exactly that cycle.
//  - Latency: start at E0 -> result_valid high in cycle following E32.
//  - overflow = (A[WIDTH-1:0] != {WIDTH{Q[WIDTH-1]}}), i.e. high word not sign-ext of low.
//  - start while busy=1: ignored, no queuing, operands not re-sampled.
//  - start in DONE cycle: accepted; result_valid still pulses that cycle; outputs hold
//    previous result until the new one completes.
//  - Operand changes while busy: no effect.
//  - result_valid never asserts for an operation aborted by reset.
// CONFIGURATION
//  MULT_PRODUCT_HI_EN defined: product_hi port exists, registered as above.
//  Not defined: port and its WIDTH-bit output register removed. overflow is still
//  computed from internal A. Timing and all other outputs are identical either way.
// STRUCTURE
//  Shared package multdiv_pkg:
//    - state typedef {IDLE, RUN, DONE}
//    - MULT_ITER = 32 constant
//    - Booth code constants (BOOTH_NOP, BOOTH_ADD, BOOTH_SUB)
//  Sub-module booth_step: combinational. Takes A, M, {Q[0],q_m1}; returns the
//  shifted {A,Q,q_m1}. Contains the single WIDTH+1 add/sub. The top holds FSM,
//  counter and registers only.
// TESTING
//  1. 3 x 4 -> product=0x0000000C, overflow=0, result_valid pulse after exactly 33 cycles.
//  2. -7 x 6 -> product=0xFFFFFFD6 (-42), overflow=0; product_hi=0xFFFFFFFF when enabled.
//  3. 0x7FFFFFFF x 2 -> product=0xFFFFFFFE, overflow=1; 0x80000000 x 0xFFFFFFFF
//     -> product=0x80000000, overflow=1.
//  4. Reset asserted at step 10 of a run -> next cycle busy=0, product=0,
//     no result_valid afterwards.
//  5. start pulsed again at step 5 with other operands -> ignored; first result correct.
//  6. start in the DONE cycle (5 x 5 after 2 x 3) -> product 6 pulses, then 25
//     exactly 33 cycles later.
//  Random: 10k signed pairs vs $signed 64-bit reference, both macro settings.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide units.
// Holds the FSM state encoding, the iteration count and the radix-2 Booth codes.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int MULT_ITER = 32;

    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // {Q[0], q_m1}: 01 ends a run of ones (add), 10 starts one (subtract), 00/11 do nothing.
    function automatic logic [1:0] booth_decode(input logic [1:0] pair);
        case (pair)
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_seq_multiplier_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of {A,Q,q_m1}. Purely combinational.
module booth_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MULT_ITER
) (
    input  logic signed [WIDTH:0]   acc,
    input  logic signed [WIDTH-1:0] mcand,
    input  logic        [WIDTH-1:0] q,
    input  logic                    q_m1,
    output logic signed [WIDTH:0]   acc_next,
    output logic        [WIDTH-1:0] q_next,
    output logic                    q_m1_next
);

    logic        [1:0]     code;
    logic signed [WIDTH:0] m_ext;
    logic signed [WIDTH:0] addend;
    logic                  carry_in;
    logic signed [WIDTH:0] sum;

    // The extra bit keeps -M representable when M is the most negative value.
    // Subtraction reuses the single adder as A + ~M + 1.
    always_comb begin
        code     = booth_decode({q[0], q_m1});
        m_ext    = {mcand[WIDTH-1], mcand};
        addend   = '0;
        carry_in = 1'b0;
        case (code)
            BOOTH_ADD: begin
                addend   = m_ext;
                carry_in = 1'b0;
            end
            BOOTH_SUB: begin
                addend   = ~m_ext;
                carry_in = 1'b1;
            end
            default: begin
                addend   = '0;
                carry_in = 1'b0;
            end
        endcase
        sum       = acc + addend + {{WIDTH{1'b0}}, carry_in};
        acc_next  = {sum[WIDTH], sum[WIDTH:1]};
        q_next    = {sum[0], q[WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Multi-cycle signed WIDTHxWIDTH radix-2 Booth multiplier, one add/sub step per clock.
// Define MULT_PRODUCT_HI_EN to expose the registered high product word on product_hi.
module booth_seq_multiplier
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MULT_ITER,
    parameter int CNT_W = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] multiplicand,
    input  logic signed [WIDTH-1:0] multiplier,
    output logic                    busy,
    output logic                    result_valid,
    output logic        [WIDTH-1:0] product,
    output logic                    overflow
`ifdef MULT_PRODUCT_HI_EN
    ,
    output logic        [WIDTH-1:0] product_hi
`endif
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mult_state_t               state;
    logic        [CNT_W-1:0]   iter_cnt;
    logic signed [WIDTH-1:0]   m_reg;
    logic signed [WIDTH:0]     acc;
    logic        [WIDTH-1:0]   q_reg;
    logic                      q_m1;

    logic signed [WIDTH:0]     acc_next;
    logic        [WIDTH-1:0]   q_next;
    logic                      q_m1_next;

    // High word must equal the sign extension of the low word for the product to fit.
    function automatic logic hi_not_sign_ext(input logic [WIDTH-1:0] hi,
                                             input logic [WIDTH-1:0] lo);
        return hi != {WIDTH{lo[WIDTH-1]}};
    endfunction

    booth_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc       (acc),
        .mcand     (m_reg),
        .q         (q_reg),
        .q_m1      (q_m1),
        .acc_next  (acc_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            product      <= '0;
            overflow     <= 1'b0;
            iter_cnt     <= '0;
`ifdef MULT_PRODUCT_HI_EN
            product_hi   <= '0;
`endif
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        m_reg    <= multiplicand;
                        acc      <= '0;
                        q_reg    <= multiplier;
                        q_m1     <= 1'b0;
                        iter_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    acc      <= acc_next;
                    q_reg    <= q_next;
                    q_m1     <= q_m1_next;
                    iter_cnt <= iter_cnt + CNT_W'(1);
                    // Last step: publish straight from the step outputs so the result
                    // is visible in the same cycle the FSM reaches DONE.
                    if (iter_cnt == LAST_ITER) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        product      <= q_next;
                        overflow     <= hi_not_sign_ext(acc_next[WIDTH-1:0], q_next);
`ifdef MULT_PRODUCT_HI_EN
                        product_hi   <= acc_next[WIDTH-1:0];
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
